// File: rtl/rnd_pkg.sv
// Shared types and constants for the CCSDS randomizer frame controller and its randomizer.
package rnd_pkg;

   localparam int unsigned SYM_W = 2;

   // Gold-sequence LFSR seeds loaded by the companion randomizer on reseed
   localparam logic [17:0] X_SEED = 18'h00001;
   localparam logic [17:0] Y_SEED = 18'h3FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEED = 2'd1,
      RUN  = 2'd2
   } state_t;

   typedef struct packed {
      logic [SYM_W-1:0] data;
      logic             last;
   } beat_t;

endpackage

// File: rtl/randomizer_frame_ctrl.sv
// Frame sequencer and symbol scrambler driving an external CCSDS Gold-sequence randomizer.
// Optional RND_BYPASS_EN adds i_bypass to pass symbols through unscrambled.
module randomizer_frame_ctrl
   import rnd_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 1024,
   parameter int unsigned CNT_W     = 11
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic             i_continuous,
   input  logic             i_abort,
   input  logic             i_valid,
   input  logic [SYM_W-1:0] i_data,
`ifdef RND_BYPASS_EN
   input  logic             i_bypass,
`endif
   output logic             o_ready,
   output logic             o_valid,
   output logic [SYM_W-1:0] o_data,
   output logic             o_last,
   input  logic             i_out_ready,
   output logic             o_rnd_reset,
   output logic             o_rnd_en,
   input  logic [SYM_W-1:0] i_rnd,
   output logic             o_busy
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   beat_t            beat_q;
   logic             valid_q;

   logic             abort_taken_c;
   logic             accept_c;
   logic             last_sym_c;
   logic [SYM_W-1:0] mask_c;

   // A reset arriving mid-frame is treated exactly like an abort
   assign abort_taken_c = (i_abort | ~i_reset_n) & (state_q != IDLE);
   assign last_sym_c    = (cnt_q == LAST_CNT);
   assign o_ready       = (state_q == RUN) & i_reset_n & ~i_abort & (~valid_q | i_out_ready);
   assign accept_c      = i_valid & o_ready;

`ifdef RND_BYPASS_EN
   assign mask_c = i_bypass ? '0 : i_rnd;
`else
   assign mask_c = i_rnd;
`endif

   // Frame sequencing: one reseed cycle before every frame, abort overrides all
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_start) state_d = SEED;
         SEED: state_d = RUN;
         RUN: begin
            if (accept_c && last_sym_c) state_d = i_continuous ? SEED : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort_taken_c) state_d = IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) state_q <= IDLE;
      else            state_q <= state_d;
   end

   // Symbol counter and single-entry output register
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (abort_taken_c) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (accept_c) begin
         beat_q  <= '{data: i_data ^ mask_c, last: last_sym_c};
         valid_q <= 1'b1;
         cnt_q   <= last_sym_c ? '0 : cnt_q + CNT_W'(1);
      end else if (valid_q && i_out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign o_valid     = valid_q;
   assign o_data      = beat_q.data;
   assign o_last      = beat_q.last;
   assign o_busy      = (state_q != IDLE);
   assign o_rnd_en    = accept_c;
   assign o_rnd_reset = ~i_reset_n | (state_q == SEED) | abort_taken_c;

endmodule

// File: tb/tb_randomizer_frame_ctrl.sv
// Self-checking bench for randomizer_frame_ctrl with a table-driven stand-in randomizer.
module tb_randomizer_frame_ctrl;
   import rnd_pkg::*;

   localparam int unsigned FL = 4;
   localparam int unsigned CW = 2;
`ifdef RND_BYPASS_EN
   localparam bit BYP_ON = 1'b1;
`else
   localparam bit BYP_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, cont, abort, valid, out_ready, byp;
   logic [1:0] data;
   logic       ready, ovalid, olast, rnd_reset, rnd_en, busy;
   logic [1:0] odata, rnd;

   randomizer_frame_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_continuous(cont),
      .i_abort(abort), .i_valid(valid), .i_data(data),
`ifdef RND_BYPASS_EN
      .i_bypass(byp),
`endif
      .o_ready(ready), .o_valid(ovalid), .o_data(odata), .o_last(olast),
      .i_out_ready(out_ready), .o_rnd_reset(rnd_reset), .o_rnd_en(rnd_en),
      .i_rnd(rnd), .o_busy(busy)
   );

   // Stand-in randomizer: chip sequence from a random table, reseed to index 0, step on enable
   logic [1:0] chip_tab [16];
   logic [3:0] ridx;
   always_ff @(posedge clk) begin
      if (rnd_reset)   ridx <= '0;
      else if (rnd_en) ridx <= ridx + 4'd1;
   end
   assign rnd = chip_tab[ridx];

   // Reference model: frame position, reseed bubble, and queue of beats owed downstream
   int         passed = 0;
   int         total  = 0;
   logic [2:0] expq [$];
   bit         framing = 0;
   bit         bubble  = 0;
   int         pos     = 0;
   logic [1:0] prev_odata;
   bit         prev_stall = 0;

   function automatic logic [4:0] exp_ctl();
      logic ev, er, erst;
      ev   = (expq.size() != 0);
      er   = rst_n && framing && !bubble && !abort && (!ev || out_ready);
      erst = !rst_n || (framing && (bubble || abort));
      return {ev, er, framing, erst, valid && er};
   endfunction

   task automatic model_step();
      logic [4:0] c;
      logic [1:0] m;
      c = exp_ctl();
      if (!rst_n || (abort && framing)) begin
         expq.delete(); framing = 0; bubble = 0; pos = 0;
      end else begin
         if (expq.size() != 0 && out_ready) void'(expq.pop_front());
         if (c[0]) begin
            m = (byp && BYP_ON) ? 2'b00 : chip_tab[pos];
            expq.push_back({data ^ m, pos == FL - 1});
            if (pos == FL - 1) begin
               pos = 0;
               if (cont) bubble = 1; else framing = 0;
            end else pos++;
         end else if (bubble) bubble = 0;
         else if (!framing && start) begin framing = 1; bubble = 1; end
      end
   endtask

   task automatic drive(input bit r, input bit st, input bit ct, input bit ab, input bit v,
                        input logic [1:0] d, input bit ordy, input bit bp);
      @(posedge clk); #1;
      rst_n = r; start = st; cont = ct; abort = ab; valid = v; data = d;
      out_ready = ordy; byp = bp;
      #1;
   endtask

   task automatic test_reset();
      drive(0, 1, 1, 1, 1, 2'd3, 1, 0);
      model_step();
      for (int c = 0; c < 4; c++) begin
         drive(c >= 2, c != 3, 0, c == 2, 1, 2'd1, 1, 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL reset ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         total++;
         if ({odata, olast} !== 3'b000) $display("FAIL reset out c=%0d got %b want 000", c, {odata, olast});
         else passed++;
         model_step();
      end
   endtask

   task automatic test_single_frame();
      for (int c = 0; c < 8; c++) begin
         drive(1, c == 0, 0, 0, 1, 2'd0, 1, 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL single ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL single beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask

   task automatic test_continuous();
      for (int c = 0; c < 20; c++) begin
         drive(1, c == 0, c < 12, 0, 1, 2'($urandom_range(0, 3)), 1, 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL continuous ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL continuous beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask

   task automatic test_backpressure();
      prev_stall = 0;
      for (int c = 0; c < 14; c++) begin
         drive(1, c == 0, 0, 0, 1, 2'd0, !(c >= 4 && c < 7), 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL stall ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL stall beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         if (prev_stall) begin
            total++;
            if (odata !== prev_odata) $display("FAIL stall hold c=%0d got %b want %b", c, odata, prev_odata);
            else passed++;
         end
         prev_stall = ovalid && !out_ready;
         prev_odata = odata;
         model_step();
      end
   endtask

   task automatic test_abort();
      for (int c = 0; c < 16; c++) begin
         drive(1, c == 0 || c == 8, 0, c == 5 || c == 7, 1, 2'($urandom_range(0, 3)), 1, 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL abort ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL abort beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask

   task automatic test_data_ones_start_held();
      for (int c = 0; c < 14; c++) begin
         drive(1, 1, 0, 0, 1, 2'd3, 1, 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL ones ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL ones beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask

`ifdef RND_BYPASS_EN
   task automatic test_bypass();
      for (int c = 0; c < 8; c++) begin
         drive(1, c == 0, 0, 0, 1, 2'($urandom_range(0, 3)), 1, c == 3);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL bypass ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL bypass beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 20, $urandom_range(0, 1) == 1,
               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 70, $urandom_range(0, 3) == 0);
         total++;
         if ({ovalid, ready, busy, rnd_reset, rnd_en} !== exp_ctl()) begin
            $display("FAIL random ctl c=%0d got %b want %b", c, {ovalid, ready, busy, rnd_reset, rnd_en}, exp_ctl());
         end else passed++;
         if (expq.size() != 0) begin
            total++;
            if ({odata, olast} !== expq[0]) $display("FAIL random beat c=%0d got %b want %b", c, {odata, olast}, expq[0]);
            else passed++;
         end
         model_step();
      end
   endtask

   initial begin
      rst_n = 0; start = 0; cont = 0; abort = 0; valid = 0; data = '0; out_ready = 1; byp = 0;
      for (int i = 0; i < 16; i++) chip_tab[i] = 2'($urandom_range(0, 3));
      test_reset();
      test_single_frame();
      test_continuous();
      test_backpressure();
      test_abort();
      test_data_ones_start_held();
`ifdef RND_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
